// File: rtl/pkt_asm.sv
// Word-to-packet assembler: gathers WORDS_PER_PACKET words over a valid/ready
// input and holds the packed result on a valid/ready output until taken.
module pkt_asm #(
  parameter int WORD_SIZE        = 8,
  parameter int WORDS_PER_PACKET = 4,
  parameter int LSB_FIRST        = 1,
  parameter int TIMEOUT_CYCLES   = 0,
  parameter int DROP_CTR_WIDTH   = 8
) (
  input  logic                                  clk,
  input  logic                                  n_reset,
  input  logic [WORD_SIZE-1:0]                  in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  flush,
  output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DROP_CTR_WIDTH-1:0]             drop_count
);

  localparam int CW = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(WORDS_PER_PACKET - 1);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic {S_RX, S_HOLD} state_t;

  state_t                                   r_state, w_state_nxt;
  logic [CW-1:0]                            r_ctr, w_ctr_nxt;
  logic [TW-1:0]                            r_timer, w_timer_nxt;
  logic [DROP_CTR_WIDTH-1:0]                r_drop, w_drop_nxt;
  logic [WORDS_PER_PACKET-1:0][WORD_SIZE-1:0] r_slot;
  logic                                     r_run;
  logic                                     w_word_acc, w_pkt_acc, w_expire, w_store;
  logic [CW-1:0]                            w_idx;

  // r_run keeps in_ready low through reset without a path from n_reset
  assign in_ready   = r_run && (r_state == S_RX);
  assign out_valid  = (r_state == S_HOLD);
  assign out_data   = r_slot;
  assign drop_count = r_drop;

  assign w_word_acc = in_valid && in_ready;
  assign w_pkt_acc  = out_valid && out_ready;
  assign w_expire   = TO_EN && (r_state == S_RX) && (r_ctr != '0) &&
                      (r_timer == TLAST) && !w_word_acc;
  assign w_idx      = (LSB_FIRST != 0) ? r_ctr : (LAST - r_ctr);

  always_comb begin
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ctr;
    w_drop_nxt  = r_drop;
    w_store     = 1'b0;
    if (!TO_EN || w_word_acc || (r_ctr == '0) || (r_state != S_RX) || w_expire)
      w_timer_nxt = '0;
    else
      w_timer_nxt = r_timer + 1'b1;

    if (flush) begin
      w_state_nxt = S_RX;
      w_ctr_nxt   = '0;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        S_RX: begin
          if (w_word_acc) begin
            w_store = 1'b1;
            if (r_ctr == LAST) begin
              w_ctr_nxt   = '0;
              w_state_nxt = S_HOLD;
            end else begin
              w_ctr_nxt = r_ctr + 1'b1;
            end
          end else if (w_expire) begin
            w_ctr_nxt = '0;
            if (r_drop != '1) w_drop_nxt = r_drop + 1'b1;
          end
        end
        S_HOLD: if (w_pkt_acc) w_state_nxt = S_RX;
        default: w_state_nxt = S_RX;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= S_RX;
      r_ctr   <= '0;
      r_timer <= '0;
      r_drop  <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ctr   <= w_ctr_nxt;
      r_timer <= w_timer_nxt;
      r_drop  <= w_drop_nxt;
      r_run   <= 1'b1;
    end
  end

  // Slots are not cleared on discard; they are simply overwritten next packet
  for (genvar k = 0; k < WORDS_PER_PACKET; k++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!n_reset)
        r_slot[k] <= '0;
      else if (w_store && (w_idx == CW'(k)))
        r_slot[k] <= in_data;
    end
  end

endmodule
